// File: rtl/usb_rx_timing_ctrl_pkg.sv
// Shared state type and timing constants for the USB full-speed RX timing controller.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SYNC_RX   = 3'd1,
    SYNC_CHK  = 3'd2,
    DATA_RX   = 3'd3,
    BYTE_DONE = 3'd4,
    EOP_WAIT  = 3'd5,
    ERR_WAIT  = 3'd6
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam int CLKS_PER_BIT_DEF  = 8;
  localparam int SAMPLE_POINT_DEF  = 3;
  localparam int BITS_PER_BYTE_DEF = 8;

endpackage

// File: rtl/usb_rx_timing_ctrl_if.sv
// Line-side inputs and RX-path strobes/status of the USB RX timing controller.
interface usb_rx_timing_ctrl_if;

  logic       d_edge;
  logic       eop;
  logic [7:0] rcv_data;
  logic       shift_enable;
  logic       byte_received;
  logic       rcving;
  logic       r_error;

  // The controller is the slave: it consumes line events and produces strobes.
  modport slave (
    input  d_edge, eop, rcv_data,
    output shift_enable, byte_received, rcving, r_error
  );

  modport master (
    output d_edge, eop, rcv_data,
    input  shift_enable, byte_received, rcving, r_error
  );

endinterface

// File: rtl/usb_rx_timing_ctrl_rx_bit_timer.sv
// Wrap counter with synchronous clear and count enable; used for bit timing and bit counting.
module rx_bit_timer #(
  parameter int WIDTH = 3,
  parameter int WRAP  = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  output logic [WIDTH-1:0] count_out
);

  localparam logic [WIDTH-1:0] WRAP_V = WIDTH'(WRAP);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Clear wins over increment so a resync always lands on zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_enable) begin
      cnt_d = (cnt_q == WRAP_V) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_out = cnt_q;

endmodule

// File: rtl/usb_rx_timing_ctrl.sv
// USB full-speed RX timing and framing controller: bit-sample strobe, SYNC check,
// byte delivery, EOP handling and framing-error recovery.
//
// state     | meaning
// IDLE      | bus idle, waiting for the first D+ transition
// SYNC_RX   | shifting in the 8 SYNC bits
// SYNC_CHK  | one cycle: compare rcv_data against SYNC_BYTE
// DATA_RX   | shifting in data bits
// BYTE_DONE | one cycle: byte_received, rcv_data holds a full byte
// EOP_WAIT  | clean end of packet, waiting for SE0 to clear
// ERR_WAIT  | framing error, waiting for an SE0 to come and go
module usb_rx_timing_ctrl
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT  = CLKS_PER_BIT_DEF,
  parameter int SAMPLE_POINT  = SAMPLE_POINT_DEF,
  parameter int BITS_PER_BYTE = BITS_PER_BYTE_DEF
) (
  input  logic                 clk,
  input  logic                 n_rst,
  usb_rx_timing_ctrl_if.slave  rx
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = (BITS_PER_BYTE > 1) ? $clog2(BITS_PER_BYTE) : 1;
  localparam logic [TW-1:0] SAMPLE_V   = TW'(SAMPLE_POINT);
  localparam logic [CW-1:0] LAST_BIT_V = CW'(BITS_PER_BYTE - 1);

  rx_state_t     state_q, state_d;
  logic          r_error_q, r_error_d;
  logic          eop_seen_q, eop_seen_d;
  logic          tmr_clear, tmr_en;
  logic          cnt_clear, cnt_en;
  logic          sample_pt, last_bit;
  logic [TW-1:0] bit_timer;
  logic [CW-1:0] bit_count;

  rx_bit_timer #(
    .WIDTH (TW),
    .WRAP  (CLKS_PER_BIT - 1)
  ) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (tmr_clear),
    .count_enable (tmr_en),
    .count_out    (bit_timer)
  );

  rx_bit_timer #(
    .WIDTH (CW),
    .WRAP  (BITS_PER_BYTE - 1)
  ) u_bit_count (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .count_out    (bit_count)
  );

  assign tmr_en    = (state_q != IDLE);
  assign tmr_clear = (state_q == IDLE) || rx.d_edge;
  assign sample_pt = ((state_q == SYNC_RX) || (state_q == DATA_RX)) && (bit_timer == SAMPLE_V);
  // An SE0 at a sample point is a line condition, not a data bit.
  assign cnt_en    = sample_pt && !rx.eop;
  assign last_bit  = cnt_en && (bit_count == LAST_BIT_V);

  always_comb begin
    state_d    = state_q;
    r_error_d  = r_error_q;
    eop_seen_d = 1'b0;
    cnt_clear  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        if (rx.d_edge) begin
          state_d   = SYNC_RX;
          r_error_d = 1'b0;
        end
      end
      SYNC_RX: begin
        if (sample_pt && rx.eop) begin
          state_d = ERR_WAIT;
        end else if (last_bit) begin
          state_d = SYNC_CHK;
        end
      end
      SYNC_CHK: begin
        cnt_clear = 1'b1;
        state_d   = (rx.rcv_data == SYNC_BYTE) ? DATA_RX : ERR_WAIT;
      end
      DATA_RX: begin
        if (sample_pt && rx.eop) begin
          state_d = (bit_count == '0) ? EOP_WAIT : ERR_WAIT;
        end else if (last_bit) begin
          state_d = BYTE_DONE;
        end
      end
      BYTE_DONE: begin
        cnt_clear = 1'b1;
        state_d   = DATA_RX;
      end
      EOP_WAIT: begin
        if (!rx.eop) begin
          state_d = IDLE;
        end
      end
      ERR_WAIT: begin
        if (eop_seen_q && !rx.eop) begin
          state_d = IDLE;
        end else begin
          eop_seen_d = eop_seen_q || rx.eop;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d == ERR_WAIT) begin
      r_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      r_error_q  <= 1'b0;
      eop_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_error_q  <= r_error_d;
      eop_seen_q <= eop_seen_d;
    end
  end

  assign rx.shift_enable  = sample_pt;
  assign rx.byte_received = (state_q == BYTE_DONE);
  assign rx.rcving        = (state_q != IDLE);
  assign rx.r_error       = r_error_q;

endmodule

// File: tb/tb_usb_rx_timing_ctrl.sv
// Randomized directed bench for usb_rx_timing_ctrl against a packet-level timing model.
module tb_usb_rx_timing_ctrl;
  import usb_rx_pkg::*;

  localparam int CPB = 8;
  localparam int SP  = 3;

  logic       clk      = 1'b0;
  logic       n_rst    = 1'b0;
  logic [7:0] sr       = 8'h00;
  logic       prev_err = 1'b0;
  int         errors   = 0;
  int         checks   = 0;

  usb_rx_timing_ctrl_if rx ();

  usb_rx_timing_ctrl #(
    .CLKS_PER_BIT  (CPB),
    .SAMPLE_POINT  (SP),
    .BITS_PER_BYTE (8)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .rx    (rx)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A bit is sampled SP+1 cycles after the latest line edge, then every CPB cycles.
  function automatic bit shift_rule(input int c, input int edges[$]);
    int e;
    e = -1000;
    foreach (edges[i]) if (edges[i] < c && edges[i] > e) e = edges[i];
    return (c - e >= SP + 1) && ((c - e - SP - 1) % CPB == 0);
  endfunction

  task automatic run_packet(input string name, input logic [7:0] sync_b,
                            input logic [7:0] data_q[$], input int data_bits,
                            input bit jit_en, input int forced, input int gap,
                            input int abort_at);
    int   bits[$];
    int   edges[$];
    int   nb, r_c, f_c, n, nsh, nbr_exp, nbr_obs, err_at, c_e, idx, jit;
    bit   stopped;
    logic de[];
    logic ep[];
    logic exp_se[];
    logic exp_br[];
    logic exp_rc[];
    logic exp_er[];

    for (int i = 0; i < 8; i++) bits.push_back(int'(sync_b[i]));
    for (int j = 0; j < data_bits; j++) bits.push_back(int'(data_q[j/8][j%8]));
    if (sync_b != SYNC_BYTE)
      for (int j = 0; j < 16; j++) bits.push_back(int'($urandom_range(0, 1)));
    nb = bits.size();

    edges.push_back(0);
    for (int k = 1; k < nb; k++) begin
      if (bits[k] == 0 || k == forced) begin
        jit = (k == forced) ? -1 : (jit_en ? int'($urandom_range(0, 2)) - 1 : 0);
        edges.push_back(CPB * k + jit);
      end
    end

    r_c = CPB * nb + 1;
    f_c = r_c + 2 * CPB;
    n   = f_c + gap + 1;
    de = new[n]; ep = new[n]; exp_se = new[n]; exp_br = new[n]; exp_rc = new[n]; exp_er = new[n];
    for (int c = 0; c < n; c++) begin
      de[c] = 1'b0; exp_se[c] = 1'b0; exp_br[c] = 1'b0;
    end

    err_at = -1; nsh = 0; nbr_exp = 0; stopped = 1'b0;
    for (int c = 1; c < r_c; c++) begin
      if (!stopped && shift_rule(c, edges)) begin
        exp_se[c] = 1'b1;
        nsh++;
        if (nsh == 8 && sync_b != SYNC_BYTE) begin
          err_at  = c + 2;
          stopped = 1'b1;
        end else if (nsh > 8 && (nsh - 8) % 8 == 0) begin
          exp_br[c+1] = 1'b1;
          nbr_exp++;
        end
      end
    end
    if (!stopped) begin
      c_e = r_c;
      while (!shift_rule(c_e, edges) && c_e < r_c + 2 * CPB) c_e++;
      if ((nsh - 8) % 8 != 0) err_at = c_e + 1;
    end

    for (int c = 0; c < n; c++) begin
      exp_rc[c] = (c >= 1 && c <= f_c);
      exp_er[c] = (c == 0) ? prev_err : (err_at >= 0 && c >= err_at);
      ep[c]     = (c >= r_c && c < f_c);
    end
    foreach (edges[i]) de[edges[i]] = 1'b1;

    idx = 0; nbr_obs = 0;
    for (int c = 0; c < n; c++) begin
      chk_bit({name, " rcving"}, rx.rcving, exp_rc[c]);
      chk_bit({name, " r_error"}, rx.r_error, exp_er[c]);
      chk_bit({name, " byte_received"}, rx.byte_received, exp_br[c]);
      if (!ep[c]) chk_bit({name, " shift_enable"}, rx.shift_enable, exp_se[c]);
      if (rx.byte_received) nbr_obs++;
      if (c >= 1 && exp_se[c-1]) begin
        sr = {1'(bits[idx]), sr[7:1]};
        idx++;
      end
      rx.rcv_data = sr;
      rx.d_edge   = de[c];
      rx.eop      = ep[c];
      if (c == abort_at) begin
        #2 n_rst = 1'b0;
        #1;
        chk_bit({name, " async rcving"}, rx.rcving, 1'b0);
        chk_bit({name, " async shift_enable"}, rx.shift_enable, 1'b0);
        chk_bit({name, " async byte_received"}, rx.byte_received, 1'b0);
        chk_bit({name, " async r_error"}, rx.r_error, 1'b0);
        rx.d_edge = 1'b0;
        rx.eop    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
          chk_bit({name, " post rcving"}, rx.rcving, 1'b0);
          chk_bit({name, " post byte_received"}, rx.byte_received, 1'b0);
          chk_bit({name, " post shift_enable"}, rx.shift_enable, 1'b0);
          tick();
        end
        prev_err = 1'b0;
        return;
      end
      tick();
    end
    chk_int({name, " byte count"}, nbr_obs, nbr_exp);
    prev_err = (err_at >= 0);
  endtask

  initial begin
    logic [7:0] dq[$];
    rx.d_edge   = 1'b0;
    rx.eop      = 1'b0;
    rx.rcv_data = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk_bit("reset shift_enable", rx.shift_enable, 1'b0);
    chk_bit("reset byte_received", rx.byte_received, 1'b0);
    chk_bit("reset rcving", rx.rcving, 1'b0);
    chk_bit("reset r_error", rx.r_error, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    chk_bit("released rcving", rx.rcving, 1'b0);

    dq.delete(); dq.push_back(8'hA5); dq.push_back(8'h3C);
    run_packet("valid", SYNC_BYTE, dq, 16, 1'b1, -1, 4, -1);

    dq.delete(); dq.push_back(8'($urandom));
    run_packet("resync", SYNC_BYTE, dq, 8, 1'b0, 10, 4, -1);

    dq.delete();
    run_packet("bad_sync", 8'h81, dq, 0, 1'b1, -1, 6, -1);

    dq.delete(); dq.push_back(8'($urandom));
    run_packet("early_eop", SYNC_BYTE, dq, 5, 1'b1, -1, 2, -1);

    dq.delete(); dq.push_back(8'($urandom)); dq.push_back(8'($urandom));
    run_packet("back_to_back", SYNC_BYTE, dq, 16, 1'b1, -1, 3, -1);

    for (int p = 0; p < 3; p++) begin
      int nbytes;
      nbytes = int'($urandom_range(1, 3));
      dq.delete();
      for (int b = 0; b < nbytes; b++) dq.push_back(8'($urandom));
      run_packet("random", SYNC_BYTE, dq, 8 * nbytes, 1'b1, -1, int'($urandom_range(2, 5)), -1);
    end

    dq.delete(); dq.push_back(8'($urandom)); dq.push_back(8'($urandom));
    run_packet("reset_mid", SYNC_BYTE, dq, 16, 1'b1, -1, 4, 98);

    dq.delete(); dq.push_back(8'($urandom));
    run_packet("after_reset", SYNC_BYTE, dq, 8, 1'b1, -1, 3, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
